// File: rtl/alu_pkg.sv
// Shared width and opcode encodings for the 8-bit ALU and the instruction decoder.
package alu_pkg;

  localparam int unsigned AluWidth = 8;
  localparam int unsigned OpWidth  = 4;

  typedef enum logic [OpWidth-1:0] {
    OpAdd   = 4'h0,
    OpSub   = 4'h1,
    OpAnd   = 4'h2,
    OpOr    = 4'h3,
    OpXor   = 4'h4,
    OpNot   = 4'h5,
    OpLand  = 4'h6,
    OpLor   = 4'h7,
    OpLxor  = 4'h8,
    OpLnot  = 4'h9,
    OpShl   = 4'hA,
    OpShr   = 4'hB,
    OpRol   = 4'hC,
    OpRor   = 4'hD,
    OpPassA = 4'hE,
    OpPassB = 4'hF
  } opcode_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, carry/borrow/shift-out and signed overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidth
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [OpWidth-1:0] i_opcode,
  input  logic               i_cin,
  output logic [WIDTH-1:0]   o_r,
  output logic               o_c,
  output logic               o_v
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic           w_a_nz;
  logic           w_b_nz;

  // Bit WIDTH of the difference is set exactly when a < b + cin, i.e. the borrow.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, i_cin};
  assign w_a_nz = |i_a;
  assign w_b_nz = |i_b;

  always_comb begin
    o_r = '0;
    o_c = 1'b0;
    o_v = 1'b0;
    case (opcode_e'(i_opcode))
      OpAdd: begin
        o_r = w_sum[WIDTH-1:0];
        o_c = w_sum[WIDTH];
        o_v = (i_a[WIDTH-1] == i_b[WIDTH-1]) & (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OpSub: begin
        o_r = w_diff[WIDTH-1:0];
        o_c = w_diff[WIDTH];
        o_v = (i_a[WIDTH-1] != i_b[WIDTH-1]) & (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      OpAnd:   o_r = i_a & i_b;
      OpOr:    o_r = i_a | i_b;
      OpXor:   o_r = i_a ^ i_b;
      OpNot:   o_r = ~i_a;
      OpLand:  o_r = {{(WIDTH-1){1'b0}}, w_a_nz & w_b_nz};
      OpLor:   o_r = {{(WIDTH-1){1'b0}}, w_a_nz | w_b_nz};
      OpLxor:  o_r = {{(WIDTH-1){1'b0}}, w_a_nz ^ w_b_nz};
      OpLnot:  o_r = {{(WIDTH-1){1'b0}}, ~w_a_nz};
      OpShl: begin
        o_r = {i_a[WIDTH-2:0], 1'b0};
        o_c = i_a[WIDTH-1];
      end
      OpShr: begin
        o_r = {1'b0, i_a[WIDTH-1:1]};
        o_c = i_a[0];
      end
      OpRol: begin
        o_r = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
        o_c = i_a[WIDTH-1];
      end
      OpRor: begin
        o_r = {i_a[0], i_a[WIDTH-1:1]};
        o_c = i_a[0];
      end
      OpPassA: o_r = i_a;
      OpPassB: o_r = i_b;
      default: o_r = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered 8-bit ALU: one operation per clock, result and Z/C/V/N flags loaded every edge.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [OpWidth-1:0] opcode,
  input  logic               cin,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               carry,
  output logic               overflow,
  output logic               negative
);

  logic [WIDTH-1:0] w_r;
  logic             w_c;
  logic             w_v;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_overflow;
  logic             r_negative;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_a     (a),
    .i_b     (b),
    .i_opcode(opcode),
    .i_cin   (cin),
    .o_r     (w_r),
    .o_c     (w_c),
    .o_v     (w_v)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_negative <= 1'b0;
    end else begin
      r_result   <= w_r;
      r_zero     <= ~|w_r;
      r_carry    <= w_c;
      r_overflow <= w_v;
      r_negative <= w_r[WIDTH-1];
    end
  end

  assign result   = r_result;
  assign zero     = r_zero;
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign negative = r_negative;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: known-answer vectors, mid-stream reset, then randomized ops against an
// integer-arithmetic reference model, with inputs changing every cycle.
module tb_alu;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] opcode;
  logic       cin;
  logic [7:0] result;
  logic       zero;
  logic       carry;
  logic       overflow;
  logic       negative;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] r;
    logic [3:0] zcvn;
  } kat_t;

  kat_t kats [21];

  alu #(
    .WIDTH(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .opcode  (opcode),
    .cin     (cin),
    .result  (result),
    .zero    (zero),
    .carry   (carry),
    .overflow(overflow),
    .negative(negative)
  );

  always #5 clk = ~clk;

  // Returns {result, Z, C, V, N} computed with plain integer arithmetic.
  function automatic logic [11:0] model(input int op, input int av, input int bv, input int c_in);
    int r, c, v, sa, sb, s;
    c  = 0;
    v  = 0;
    r  = 0;
    sa = (av >= 128) ? av - 256 : av;
    sb = (bv >= 128) ? bv - 256 : bv;
    case (op)
      0: begin
        s = av + bv + c_in; r = s % 256; c = (s > 255) ? 1 : 0;
        s = sa + sb + c_in; v = (s > 127 || s < -128) ? 1 : 0;
      end
      1: begin
        s = av - bv - c_in; c = (s < 0) ? 1 : 0; r = (s + 256) % 256;
        s = sa - sb - c_in; v = (s > 127 || s < -128) ? 1 : 0;
      end
      2:  r = av & bv;
      3:  r = av | bv;
      4:  r = av ^ bv;
      5:  r = 255 - av;
      6:  r = (av != 0 && bv != 0) ? 1 : 0;
      7:  r = (av != 0 || bv != 0) ? 1 : 0;
      8:  r = ((av != 0) != (bv != 0)) ? 1 : 0;
      9:  r = (av == 0) ? 1 : 0;
      10: begin r = (av * 2) % 256;            c = av / 128; end
      11: begin r = av / 2;                    c = av % 2;   end
      12: begin r = (av * 2) % 256 + av / 128; c = av / 128; end
      13: begin r = av / 2 + (av % 2) * 128;   c = av % 2;   end
      14: r = av;
      default: r = bv;
    endcase
    return {8'(r), (r == 0), (c != 0), (v != 0), (r >= 128)};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] exp_r, input logic [3:0] zcvn);
    check({tag, ".result"}, result, exp_r);
    check({tag, ".Z"}, {7'b0, zero}, {7'b0, zcvn[3]});
    check({tag, ".C"}, {7'b0, carry}, {7'b0, zcvn[2]});
    check({tag, ".V"}, {7'b0, overflow}, {7'b0, zcvn[1]});
    check({tag, ".N"}, {7'b0, negative}, {7'b0, zcvn[0]});
  endtask

  // Drive on the falling edge, sample 1 time unit after the following rising edge.
  task automatic apply(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                       input logic c_in, input logic rst_v);
    @(negedge clk);
    opcode = op;
    a      = av;
    b      = bv;
    cin    = c_in;
    rst    = rst_v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] exp;
    logic [3:0]  op;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rc;
    logic        rr;

    kats = '{
      '{OpAdd,   8'd10,  8'd20,  1'b0, 8'd30,  4'b0000},
      '{OpAdd,   8'd127, 8'd1,   1'b0, 8'h80,  4'b0011},
      '{OpAdd,   8'd200, 8'd100, 1'b0, 8'd44,  4'b0100},
      '{OpAdd,   8'd255, 8'd0,   1'b1, 8'h00,  4'b1100},
      '{OpSub,   8'd50,  8'd20,  1'b0, 8'd30,  4'b0000},
      '{OpSub,   8'd20,  8'd50,  1'b0, 8'hE2,  4'b0101},
      '{OpSub,   8'h80,  8'h01,  1'b0, 8'h7F,  4'b0010},
      '{OpAnd,   8'hAA,  8'hCC,  1'b1, 8'h88,  4'b0001},
      '{OpOr,    8'hAA,  8'hCC,  1'b0, 8'hEE,  4'b0001},
      '{OpXor,   8'hAA,  8'hCC,  1'b0, 8'h66,  4'b0000},
      '{OpNot,   8'hAA,  8'hCC,  1'b0, 8'h55,  4'b0000},
      '{OpLand,  8'h00,  8'h05,  1'b0, 8'h00,  4'b1000},
      '{OpLor,   8'h00,  8'h05,  1'b0, 8'h01,  4'b0000},
      '{OpLxor,  8'h00,  8'h05,  1'b0, 8'h01,  4'b0000},
      '{OpLnot,  8'h00,  8'h05,  1'b0, 8'h01,  4'b0000},
      '{OpLxor,  8'h03,  8'h05,  1'b0, 8'h00,  4'b1000},
      '{OpShl,   8'h81,  8'h00,  1'b0, 8'h02,  4'b0100},
      '{OpShr,   8'h81,  8'h00,  1'b0, 8'h40,  4'b0100},
      '{OpRol,   8'h81,  8'h00,  1'b0, 8'h03,  4'b0100},
      '{OpRor,   8'h81,  8'h00,  1'b0, 8'hC0,  4'b0101},
      '{OpPassB, 8'h81,  8'h00,  1'b1, 8'h00,  4'b1000}
    };

    rst = 1'b1; a = '0; b = '0; opcode = '0; cin = 1'b0;

    apply(OpAdd, 8'd1, 8'd1, 1'b0, 1'b1);
    check_all("reset", 8'h00, 4'b1000);

    foreach (kats[i]) begin
      apply(kats[i].op, kats[i].a, kats[i].b, kats[i].cin, 1'b0);
      check_all($sformatf("kat%0d", i), kats[i].r, kats[i].zcvn);
    end

    // Reset must win over an operation that would otherwise set C and N.
    apply(OpSub, 8'd20, 8'd50, 1'b1, 1'b1);
    check_all("midreset", 8'h00, 4'b1000);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rr = ($urandom_range(0, 19) == 0);
      if (i % 7 == 0) ra = 8'($urandom_range(0, 1) * 255);
      if (i % 11 == 0) rb = 8'h00;
      apply(op, ra, rb, rc, rr);
      exp = rr ? {8'h00, 4'b1000} : model(int'(op), int'(ra), int'(rb), int'(rc));
      check_all($sformatf("rnd%0d op%0h a%h b%h c%0d r%0d", i, op, ra, rb, rc, rr),
                exp[11:4], exp[3:0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
